video_pattern_gen: RTL and testbench

- Pixel source directly upstream of the video timing driver. Answers the driver's `data_req`/`pixel_xpos`/`pixel_ypos` with RGB565 `pixel_data` one clock later.
- Offers four test patterns, selected by a debounced push-button. Mode changes take effect only on a frame boundary.
- Pattern 3 is a box that moves one step per frame and bounces off the screen edges.

---
 rtl/video_pkg.sv | 64 ++++++
 rtl/key_debounce.sv | 46 ++++
 rtl/video_pattern_gen.sv | 111 +++++++++++
 tb/tb_video_pattern_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared colour constants, mode encodings and small types for the video pattern source.
package video_pkg;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_BOX  = 2'd3
  } mode_t;

  // One axis of the bouncing box: position plus direction (neg=1 moving toward 0).
  typedef struct packed {
    logic [10:0] pos;
    logic        neg;
  } axis_t;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

  // Advance one axis by one step, reflecting off 0 and limit.
  function automatic axis_t step_axis(input axis_t a, input logic [10:0] limit,
                                      input logic [10:0] step);
    axis_t r;
    r = a;
    if (!a.neg) begin
      if ({1'b0, a.pos} + {1'b0, step} > {1'b0, limit}) begin
        r.pos = a.pos - step;
        r.neg = 1'b1;
      end else begin
        r.pos = a.pos + step;
      end
    end else begin
      if (a.pos < step) begin
        r.pos = a.pos + step;
        r.neg = 1'b0;
      end else begin
        r.pos = a.pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces the active-low mode button; emits a one-cycle pulse on each press.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1485000
) (
  input  logic pixel_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      cnt_reg    <= '0;
      press_reg  <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        // Only a 1->0 transition of the debounced level counts as a press.
        stable_reg <= sync2_reg;
        press_reg  <= ~sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: answers timing-driver requests with RGB565 one clock later;
// pattern selected by a debounced button, switching only on frame boundaries.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int DEBOUNCE_CYC = 1485000,
  parameter int BOX_SIZE     = 64,
  parameter int BOX_STEP     = 4
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        key_n,
  input  logic        video_vs,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic [1:0]  mode
);

  localparam int          BAR_W   = H_DISP / 8;
  localparam logic [10:0] X_LIMIT = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0] STEP    = 11'(BOX_STEP);
  localparam logic [11:0] SIZE    = 12'(BOX_SIZE);

  logic        press;
  logic        tick;
  logic        vs_d_reg;
  logic        pending_reg;
  mode_t       mode_reg;
  axis_t       box_x_reg;
  axis_t       box_y_reg;
  logic [15:0] pixel_data_reg;
  logic [15:0] pix_next;
  logic [7:1]  bar_ge;
  logic [2:0]  bar_idx;
  logic        in_box;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_n),
    .press     (press)
  );

  assign tick = vs_d_reg & ~video_vs;

  // Bar boundaries as a thermometer of constant compares; the bar index is its population.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi] = (pixel_xpos >= 11'(gi * BAR_W));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bar_ge[k]) bar_idx = 3'(k);
    end
  end

  assign in_box = ({1'b0, pixel_xpos} >= {1'b0, box_x_reg.pos}) &&
                  ({1'b0, pixel_xpos} <  {1'b0, box_x_reg.pos} + SIZE) &&
                  ({1'b0, pixel_ypos} >= {1'b0, box_y_reg.pos}) &&
                  ({1'b0, pixel_ypos} <  {1'b0, box_y_reg.pos} + SIZE);

  always_comb begin
    pix_next = BLACK;
    if (data_req) begin
      case (mode_reg)
        MODE_BARS: pix_next = bar_color(bar_idx);
        MODE_GRID: pix_next = (pixel_xpos[5:0] == 6'd0 || pixel_ypos[5:0] == 6'd0) ? WHITE : BLACK;
        MODE_RAMP: pix_next = {pixel_xpos[7:3], pixel_xpos[7:2], pixel_xpos[7:3]};
        default:   pix_next = in_box ? WHITE : BLUE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_d_reg       <= 1'b1;
      pending_reg    <= 1'b0;
      mode_reg       <= MODE_BARS;
      box_x_reg      <= '0;
      box_y_reg      <= '0;
      pixel_data_reg <= '0;
    end else begin
      vs_d_reg       <= video_vs;
      pixel_data_reg <= pix_next;
      if (tick) begin
        box_x_reg <= step_axis(box_x_reg, X_LIMIT, STEP);
        box_y_reg <= step_axis(box_y_reg, Y_LIMIT, STEP);
        // A press coinciding with the tick still advances on this frame.
        if (pending_reg || press) begin
          mode_reg    <= mode_t'(mode_reg + 2'd1);
          pending_reg <= 1'b0;
        end
      end else if (press) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign pixel_data = pixel_data_reg;
  assign mode       = mode_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: pixel tables, mode sequencing, bouncing box.
module tb_video_pattern_gen;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n;
  logic        key_n;
  logic        video_vs;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [15:0] pixel_data;
  logic [1:0]  mode;

  video_pattern_gen #(
    .H_DISP(1280), .V_DISP(720), .DEBOUNCE_CYC(16), .BOX_SIZE(64), .BOX_STEP(4)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst_n  (sys_rst_n),
    .key_n      (key_n),
    .video_vs   (video_vs),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .pixel_data (pixel_data),
    .mode       (mode)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  mode_m = 2'd0;
  int          n_ticks = 0;
  vec_t        bars_tab[10];
  vec_t        ramp_tab[5];

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Drive one request; the expected pixel goes on the scoreboard and is compared a cycle later.
  task automatic req(input logic r, input logic [10:0] x, input logic [10:0] y,
                     input logic [15:0] e, input string nm);
    logic [15:0] want;
    data_req   = r;
    pixel_xpos = x;
    pixel_ypos = y;
    exp_q.push_back(e);
    step();
    want = exp_q.pop_front();
    chk($sformatf("%s(%0d,%0d)", nm, x, y), {16'd0, pixel_data}, {16'd0, want});
  endtask

  task automatic do_tick(input bit adv, input string nm);
    if (adv) mode_m = mode_m + 2'd1;
    n_ticks++;
    data_req = 1'b0;
    video_vs = 1'b0;
    step();
    chk(nm, {30'd0, mode}, {30'd0, mode_m});
    video_vs = 1'b1;
    step();
  endtask

  task automatic press_key(input string nm);
    key_n = 1'b0;
    repeat (40) step();
    key_n = 1'b1;
    repeat (40) step();
    chk(nm, {30'd0, mode}, {30'd0, mode_m});
  endtask

  // Independent triangle-wave view of one box axis after n ticks.
  function automatic int tri_pos(input int n, input int lim);
    int half;
    int k;
    half = lim / 4;
    k    = n % (2 * half);
    return (k <= half) ? k * 4 : (2 * half - k) * 4;
  endfunction

  task automatic box_checks();
    int bx;
    int by;
    bx = tri_pos(n_ticks, 1216);
    by = tri_pos(n_ticks, 656);
    $display("box after tick %0d expected at (%0d,%0d)", n_ticks, bx, by);
    req(1'b1, 11'(bx), 11'(by), 16'hFFFF, "box_tl");
    req(1'b1, 11'(bx + 63), 11'(by + 63), 16'hFFFF, "box_br");
    if (bx > 0)         req(1'b1, 11'(bx - 1), 11'(by), 16'h001F, "box_left");
    if (bx + 64 < 1280) req(1'b1, 11'(bx + 64), 11'(by), 16'h001F, "box_right");
    if (by > 0)         req(1'b1, 11'(bx), 11'(by - 1), 16'h001F, "box_above");
    if (by + 64 < 720)  req(1'b1, 11'(bx), 11'(by + 64), 16'h001F, "box_below");
  endtask

  initial begin
    bars_tab[0] = '{1'b1, 11'd159,  11'd0, 16'hFFFF};
    bars_tab[1] = '{1'b1, 11'd160,  11'd0, 16'hFFE0};
    bars_tab[2] = '{1'b1, 11'd1279, 11'd0, 16'h0000};
    bars_tab[3] = '{1'b0, 11'd0,    11'd0, 16'h0000};
    bars_tab[4] = '{1'b1, 11'd320,  11'd5, 16'h07FF};
    bars_tab[5] = '{1'b1, 11'd639,  11'd5, 16'h07E0};
    bars_tab[6] = '{1'b1, 11'd640,  11'd9, 16'hF81F};
    bars_tab[7] = '{1'b1, 11'd800,  11'd9, 16'hF800};
    bars_tab[8] = '{1'b1, 11'd960,  11'd9, 16'h001F};
    bars_tab[9] = '{1'b1, 11'd1120, 11'd9, 16'h0000};
    ramp_tab[0] = '{1'b1, 11'd8,    11'd0, 16'h0841};
    ramp_tab[1] = '{1'b1, 11'd255,  11'd0, 16'hFFFF};
    ramp_tab[2] = '{1'b1, 11'd256,  11'd0, 16'h0000};
    ramp_tab[3] = '{1'b1, 11'd100,  11'd7, 16'h632C};
    ramp_tab[4] = '{1'b0, 11'd8,    11'd0, 16'h0000};

    sys_rst_n  = 1'b0;
    key_n      = 1'b1;
    video_vs   = 1'b1;
    data_req   = 1'b1;
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd0;
    repeat (3) step();
    chk("reset_pixel", {16'd0, pixel_data}, 32'd0);
    chk("reset_mode", {30'd0, mode}, 32'd0);
    sys_rst_n = 1'b1;
    req(1'b1, 11'd0, 11'd0, 16'hFFFF, "post_reset");

    for (int i = 0; i < 10; i++)
      req(bars_tab[i].req, bars_tab[i].x, bars_tab[i].y, bars_tab[i].exp, "bars");

    // Short glitch must not register as a press.
    key_n = 1'b0;
    repeat (10) step();
    key_n = 1'b1;
    repeat (30) step();
    do_tick(1'b0, "glitch_no_adv");

    press_key("mode_held_until_tick");
    do_tick(1'b1, "adv_to_grid");
    req(1'b1, 11'd64, 11'd3,   16'hFFFF, "grid");
    req(1'b1, 11'd65, 11'd3,   16'h0000, "grid");
    req(1'b1, 11'd65, 11'd128, 16'hFFFF, "grid");

    press_key("multi_press_1");
    press_key("multi_press_2");
    press_key("multi_press_3");
    do_tick(1'b1, "adv_once_to_ramp");
    for (int i = 0; i < 5; i++)
      req(ramp_tab[i].req, ramp_tab[i].x, ramp_tab[i].y, ramp_tab[i].exp, "ramp");

    // Press pulse lands in the same cycle as the frame tick (2 sync + 16 count edges).
    key_n = 1'b0;
    data_req = 1'b0;
    repeat (18) step();
    mode_m = mode_m + 2'd1;
    n_ticks++;
    video_vs = 1'b0;
    step();
    chk("press_on_tick", {30'd0, mode}, {30'd0, mode_m});
    video_vs = 1'b1;
    repeat (40) step();
    key_n = 1'b1;
    repeat (40) step();
    box_checks();

    press_key("wrap_press");
    do_tick(1'b1, "wrap_to_bars");
    press_key("pre_reset_press");
    do_tick(1'b1, "pre_reset_grid");

    // Asynchronous reset in mid-stream with a request active.
    data_req   = 1'b1;
    pixel_xpos = 11'd64;
    pixel_ypos = 11'd0;
    step();
    sys_rst_n = 1'b0;
    #2;
    chk("midreset_pixel", {16'd0, pixel_data}, 32'd0);
    chk("midreset_mode", {30'd0, mode}, 32'd0);
    mode_m  = 2'd0;
    n_ticks = 0;
    exp_q.delete();
    step();
    sys_rst_n = 1'b1;
    req(1'b1, 11'd0, 11'd0, 16'hFFFF, "after_midreset");

    for (int i = 0; i < 3; i++) begin
      press_key("to_box_press");
      do_tick(1'b1, "to_box_tick");
    end
    box_checks();
    while (n_ticks < 305) begin
      do_tick(1'b0, "box_mode_hold");
      if (n_ticks == 164 || n_ticks == 165 || n_ticks == 304 || n_ticks == 305)
        box_checks();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
